// File: rtl/sdram_arbiter_if.sv
// Command-bus bundle between the SDRAM sub-modules (slave side) and the arbiter (master side).
interface sdram_arbiter_if #(
  parameter int ADDR_BITS = 12,
  parameter int BA_BITS   = 2
);
  logic                 init_done;
  logic [3:0]           init_cmd;
  logic [ADDR_BITS-1:0] init_addr;
  logic                 aref_req, aref_done, aref_en;
  logic [3:0]           aref_cmd;
  logic [ADDR_BITS-1:0] aref_addr;
  logic                 wr_req, wr_done, wr_en;
  logic [3:0]           wr_cmd;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [BA_BITS-1:0]   wr_ba;
  logic                 rd_req, rd_done, rd_en;
  logic [3:0]           rd_cmd;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [BA_BITS-1:0]   rd_ba;
  logic [3:0]           sdram_cmd;
  logic [ADDR_BITS-1:0] sdram_addr;
  logic [BA_BITS-1:0]   sdram_ba;
  logic [2:0]           arb_state;

  modport master (
    input  init_done, init_cmd, init_addr,
    input  aref_req, aref_done, aref_cmd, aref_addr,
    input  wr_req, wr_done, wr_cmd, wr_addr, wr_ba,
    input  rd_req, rd_done, rd_cmd, rd_addr, rd_ba,
    output aref_en, wr_en, rd_en,
    output sdram_cmd, sdram_addr, sdram_ba, arb_state
  );

  modport slave (
    output init_done, init_cmd, init_addr,
    output aref_req, aref_done, aref_cmd, aref_addr,
    output wr_req, wr_done, wr_cmd, wr_addr, wr_ba,
    output rd_req, rd_done, rd_cmd, rd_addr, rd_ba,
    input  aref_en, wr_en, rd_en,
    input  sdram_cmd, sdram_addr, sdram_ba, arb_state
  );
endinterface

// File: rtl/sdram_arbiter.sv
// SDRAM command-bus arbiter: refresh > write > read, grant held until done.
// Define SDRAM_ARB_RR_EN to alternate write/read when both request together.
module sdram_arbiter #(
  parameter int         ADDR_BITS = 12,
  parameter int         BA_BITS   = 2,
  parameter logic [3:0] NOP_CMD   = 4'b0111
) (
  input logic           sdram_clk,
  input logic           rst_n,
  sdram_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    ARBIT = 3'd1,
    AREF  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4
  } state_t;

  state_t state, nxt;
  logic   aref_pend;
  logic   prefer_rd;

`ifdef SDRAM_ARB_RR_EN
  logic last_wr;

  always_ff @(posedge sdram_clk or negedge rst_n)
    if (!rst_n)                           last_wr <= 1'b0;
    else if (state == ARBIT && nxt == WRITE) last_wr <= 1'b1;
    else if (state == ARBIT && nxt == READ)  last_wr <= 1'b0;

  assign prefer_rd = last_wr;
`else
  assign prefer_rd = 1'b0;
`endif

  always_ff @(posedge sdram_clk or negedge rst_n)
    if (!rst_n) state <= INIT;
    else        state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      INIT:  if (bus.init_done) nxt = ARBIT;
      ARBIT: begin
        if (aref_pend || bus.aref_req)                     nxt = AREF;
        else if (bus.wr_req && !(bus.rd_req && prefer_rd)) nxt = WRITE;
        else if (bus.rd_req)                               nxt = READ;
      end
      AREF:  if (bus.aref_done) nxt = ARBIT;
      WRITE: if (bus.wr_done)   nxt = ARBIT;
      READ:  if (bus.rd_done)   nxt = ARBIT;
      default: nxt = INIT;
    endcase
  end

  // Clear only happens out of ARBIT, so clear beats a coincident request there;
  // a request seen during AREF itself re-arms for another refresh.
  always_ff @(posedge sdram_clk or negedge rst_n)
    if (!rst_n)                             aref_pend <= 1'b0;
    else if (state == ARBIT && nxt == AREF) aref_pend <= 1'b0;
    else if (bus.aref_req && state != INIT) aref_pend <= 1'b1;

  always_ff @(posedge sdram_clk or negedge rst_n)
    if (!rst_n) begin
      bus.aref_en <= 1'b0;
      bus.wr_en   <= 1'b0;
      bus.rd_en   <= 1'b0;
    end else begin
      bus.aref_en <= (state == ARBIT) && (nxt == AREF);
      bus.wr_en   <= (state == ARBIT) && (nxt == WRITE);
      bus.rd_en   <= (state == ARBIT) && (nxt == READ);
    end

  // Output mux is gated by rst_n so the pins idle while reset is held.
  always_comb begin
    bus.sdram_cmd  = NOP_CMD;
    bus.sdram_addr = '0;
    bus.sdram_ba   = '0;
    if (rst_n) begin
      case (state)
        INIT:  begin bus.sdram_cmd = bus.init_cmd; bus.sdram_addr = bus.init_addr; end
        AREF:  begin bus.sdram_cmd = bus.aref_cmd; bus.sdram_addr = bus.aref_addr; end
        WRITE: begin
          bus.sdram_cmd  = bus.wr_cmd;
          bus.sdram_addr = bus.wr_addr;
          bus.sdram_ba   = bus.wr_ba;
        end
        READ:  begin
          bus.sdram_cmd  = bus.rd_cmd;
          bus.sdram_addr = bus.rd_addr;
          bus.sdram_ba   = bus.rd_ba;
        end
        default: ;
      endcase
    end
  end

  assign bus.arb_state = state;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: init, grants, refresh latching, stray done, async reset, write/read fairness.
module tb_sdram_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sdram_arbiter_if #(.ADDR_BITS(12), .BA_BITS(2)) bus ();
  sdram_arbiter dut (.sdram_clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bus(input string tag, input logic [2:0] st, input logic [3:0] cmd,
                         input logic [11:0] addr, input logic [1:0] ba);
    chk({tag, "_state"}, {29'd0, bus.arb_state}, {29'd0, st});
    chk({tag, "_cmd"},   {28'd0, bus.sdram_cmd}, {28'd0, cmd});
    chk({tag, "_addr"},  {20'd0, bus.sdram_addr}, {20'd0, addr});
    chk({tag, "_ba"},    {30'd0, bus.sdram_ba}, {30'd0, ba});
  endtask

  task automatic chk_en(input string tag, input logic a, input logic w, input logic r);
    chk(tag, {29'd0, bus.aref_en, bus.wr_en, bus.rd_en}, {29'd0, a, w, r});
  endtask

  int exp_seq [3];

  initial begin
`ifdef SDRAM_ARB_RR_EN
    exp_seq = '{3, 4, 3};
`else
    exp_seq = '{3, 3, 3};
`endif
    rst_n = 1'b0;
    bus.init_done = 0; bus.init_cmd = 4'h1; bus.init_addr = 12'h0AB;
    bus.aref_req = 0; bus.aref_done = 0; bus.aref_cmd = 4'h2; bus.aref_addr = 12'h400;
    bus.wr_req = 0; bus.wr_done = 0; bus.wr_cmd = 4'h4; bus.wr_addr = 12'h123; bus.wr_ba = 2'd2;
    bus.rd_req = 0; bus.rd_done = 0; bus.rd_cmd = 4'h5; bus.rd_addr = 12'h456; bus.rd_ba = 2'd1;

    #12;
    chk_bus("rst", 3'd0, 4'h7, 12'h000, 2'd0);
    chk_en("rst_en", 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step;
      chk_bus("init_wait", 3'd0, 4'h1, 12'h0AB, 2'd0);
      chk_en("init_en", 0, 0, 0);
    end
    bus.init_done = 1;
    step;
    chk_bus("to_arbit", 3'd1, 4'h7, 12'h000, 2'd0);
    bus.init_done = 0;

    // Done pulse while idle is ignored; init_done low no longer matters.
    bus.wr_done = 1;
    step;
    bus.wr_done = 0;
    chk_bus("idle_done", 3'd1, 4'h7, 12'h000, 2'd0);

    // Simple write grant and release.
    bus.wr_req = 1;
    step;
    chk_bus("wr_grant", 3'd3, 4'h4, 12'h123, 2'd2);
    chk_en("wr_en_on", 0, 1, 0);
    bus.wr_req = 0;
    step;
    chk_en("wr_en_off", 0, 0, 0);
    chk_bus("wr_hold", 3'd3, 4'h4, 12'h123, 2'd2);
    bus.wr_done = 1;
    step;
    bus.wr_done = 0;
    chk_bus("wr_release", 3'd1, 4'h7, 12'h000, 2'd0);

    // Refresh pulse during WRITE is latched and beats the waiting read.
    bus.wr_req = 1;
    step;
    chk_bus("wr2_grant", 3'd3, 4'h4, 12'h123, 2'd2);
    bus.wr_req = 0;
    bus.aref_req = 1;
    bus.rd_req = 1;
    step;
    bus.aref_req = 0;
    chk_en("aref_latched_no_en", 0, 0, 0);
    step;
    bus.wr_done = 1;
    step;
    bus.wr_done = 0;
    chk_bus("gap_after_wr", 3'd1, 4'h7, 12'h000, 2'd0);
    chk_en("gap_en", 0, 0, 0);
    step;
    chk_bus("aref_grant", 3'd2, 4'h2, 12'h400, 2'd0);
    chk_en("aref_en_first", 1, 0, 0);
    bus.rd_done = 1;
    step;
    bus.rd_done = 0;
    chk_bus("stray_rd_done", 3'd2, 4'h2, 12'h400, 2'd0);
    chk_en("aref_en_off", 0, 0, 0);
    bus.aref_done = 1;
    step;
    bus.aref_done = 0;
    chk_bus("aref_release", 3'd1, 4'h7, 12'h000, 2'd0);
    step;
    chk_bus("rd_grant", 3'd4, 4'h5, 12'h456, 2'd1);
    chk_en("rd_en_on", 0, 0, 1);

    // Asynchronous reset while rd_en is high.
    rst_n = 1'b0;
    #1;
    chk_bus("async_rst", 3'd0, 4'h7, 12'h000, 2'd0);
    chk_en("async_rst_en", 0, 0, 0);
    bus.rd_req = 0;
    #2;
    rst_n = 1'b1;
    step;
    chk_bus("post_rst_init", 3'd0, 4'h1, 12'h0AB, 2'd0);
    bus.init_done = 1;
    step;
    bus.init_done = 0;
    chk_bus("post_rst_arbit", 3'd1, 4'h7, 12'h000, 2'd0);
    step;
    chk_bus("post_rst_idle", 3'd1, 4'h7, 12'h000, 2'd0);

    // Both write and read held high: fairness depends on build option.
    bus.wr_req = 1;
    bus.rd_req = 1;
    for (int i = 0; i < 3; i++) begin
      step;
      chk($sformatf("both_grant%0d", i), {29'd0, bus.arb_state}, exp_seq[i]);
      if (exp_seq[i] == 3) chk_en($sformatf("both_en%0d", i), 0, 1, 0);
      else                 chk_en($sformatf("both_en%0d", i), 0, 0, 1);
      step;
      if (exp_seq[i] == 3) bus.wr_done = 1;
      else                 bus.rd_done = 1;
      step;
      bus.wr_done = 0;
      bus.rd_done = 0;
      chk($sformatf("both_gap%0d", i), {29'd0, bus.arb_state}, 32'd1);
    end

    // Refresh request in ARBIT outranks a held write.
    bus.aref_req = 1;
    step;
    bus.aref_req = 0;
    chk_bus("aref_over_wr", 3'd2, 4'h2, 12'h400, 2'd0);
    chk_en("aref_over_wr_en", 1, 0, 0);
    bus.wr_req = 0;
    bus.rd_req = 0;
    step;
    bus.aref_done = 1;
    step;
    bus.aref_done = 0;
    chk_bus("final_arbit", 3'd1, 4'h7, 12'h000, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout run=%0d", n_run);
    $fatal(1, "timeout");
  end
endmodule
